// File: rtl/cpu6_idex_stage.sv
// cpu6 ID/EX pipeline stage: latches a decoded instruction, forwards
// MEM/WB results into the rs1/rs2 operands and presents ALU operands a/b.
module cpu6_idex_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALUCTL_W = 3
) (
  input  logic                clk,
  input  logic                reset,

  // decode side
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [XLEN-1:0]     id_imm,
  input  logic                id_alusrc,
  input  logic [ALUCTL_W-1:0] id_alucontrol,
  input  logic [4:0]          id_rd,
  input  logic                id_regwrite,
  input  logic                id_branch,

  // downstream handshake and redirect
  input  logic                ex_ready,
  input  logic                flush,

  // forwarding sources
  input  logic [4:0]          mem_rd,
  input  logic                mem_regwrite,
  input  logic [XLEN-1:0]     mem_result,
  input  logic [4:0]          wb_rd,
  input  logic                wb_regwrite,
  input  logic [XLEN-1:0]     wb_result,

  // EX side
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_alu_a,
  output logic [XLEN-1:0]     ex_alu_b,
  output logic [ALUCTL_W-1:0] ex_alucontrol,
  output logic [XLEN-1:0]     ex_store_data,
  output logic [4:0]          ex_rd,
  output logic                ex_regwrite,
  output logic                ex_branch
);

  localparam int unsigned REG_W = 5;

  // Pipeline registers
  logic                r_valid;
  logic [XLEN-1:0]     r_pc;
  logic [REG_W-1:0]    r_rs1;
  logic [REG_W-1:0]    r_rs2;
  logic [XLEN-1:0]     r_rs1_data;
  logic [XLEN-1:0]     r_rs2_data;
  logic [XLEN-1:0]     r_imm;
  logic                r_alusrc;
  logic [ALUCTL_W-1:0] r_alucontrol;
  logic [REG_W-1:0]    r_rd;
  logic                r_regwrite;
  logic                r_branch;

  // Combinational handshake / forwarding nets
  logic                w_id_ready;
  logic                w_stall;
  logic                w_accept;
  logic                w_mem_hit_rs1;
  logic                w_wb_hit_rs1;
  logic                w_mem_hit_rs2;
  logic                w_wb_hit_rs2;
  logic [XLEN-1:0]     w_fwd_rs1;
  logic [XLEN-1:0]     w_fwd_rs2;

  // Handshake: slot is free when empty or being drained downstream
  always_comb begin
    w_id_ready = !r_valid || ex_ready;
    w_stall    = r_valid && !ex_ready;
    w_accept   = id_valid && w_id_ready;
  end

  // Hazard detection per operand; x0 never matches
  always_comb begin
    w_mem_hit_rs1 = mem_regwrite && (mem_rd == r_rs1) && (r_rs1 != REG_W'(0));
    w_wb_hit_rs1  = wb_regwrite  && (wb_rd  == r_rs1) && (r_rs1 != REG_W'(0));
    w_mem_hit_rs2 = mem_regwrite && (mem_rd == r_rs2) && (r_rs2 != REG_W'(0));
    w_wb_hit_rs2  = wb_regwrite  && (wb_rd  == r_rs2) && (r_rs2 != REG_W'(0));
  end

  // rs1 operand select: MEM is the younger result, so it wins over WB
  always_comb begin
    w_fwd_rs1 = r_rs1_data;
    if (w_mem_hit_rs1) begin
      w_fwd_rs1 = mem_result;
    end else if (w_wb_hit_rs1) begin
      w_fwd_rs1 = wb_result;
    end
  end

  // rs2 operand select, same priority as rs1
  always_comb begin
    w_fwd_rs2 = r_rs2_data;
    if (w_mem_hit_rs2) begin
      w_fwd_rs2 = mem_result;
    end else if (w_wb_hit_rs2) begin
      w_fwd_rs2 = wb_result;
    end
  end

  // Valid bit: flush kills, accept fills, idle-ready drains, stall holds
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_id_ready) begin
      r_valid <= id_valid;
    end
  end

  // Instruction fields other than operand data: captured only on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_imm        <= '0;
      r_alusrc     <= 1'b0;
      r_alucontrol <= '0;
      r_rd         <= '0;
      r_regwrite   <= 1'b0;
      r_branch     <= 1'b0;
    end else if (!flush && w_accept) begin
      r_pc         <= id_pc;
      r_rs1        <= id_rs1;
      r_rs2        <= id_rs2;
      r_imm        <= id_imm;
      r_alusrc     <= id_alusrc;
      r_alucontrol <= id_alucontrol;
      r_rd         <= id_rd;
      r_regwrite   <= id_regwrite;
      r_branch     <= id_branch;
    end
  end

  // Operand data: loaded on accept, refreshed with forwarded values while
  // stalled so a producer leaving WB mid-stall is not lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        r_rs1_data <= id_rs1_data;
        r_rs2_data <= id_rs2_data;
      end else if (w_stall) begin
        r_rs1_data <= w_fwd_rs1;
        r_rs2_data <= w_fwd_rs2;
      end
    end
  end

  // Output drive; control strobes are gated so bubbles never act
  always_comb begin
    id_ready      = w_id_ready;
    ex_valid      = r_valid;
    ex_pc         = r_pc;
    ex_alu_a      = w_fwd_rs1;
    ex_alu_b      = r_alusrc ? r_imm : w_fwd_rs2;
    ex_alucontrol = r_alucontrol;
    ex_store_data = w_fwd_rs2;
    ex_rd         = r_rd;
    ex_regwrite   = r_regwrite && r_valid;
    ex_branch     = r_branch && r_valid;
  end

endmodule

// File: tb/tb_cpu6_idex_stage.sv
// Directed bench for cpu6_idex_stage: accept, forwarding priority, x0
// guard, stall refresh, flush priority and asynchronous reset.
module tb_cpu6_idex_stage;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned ALUCTL_W = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic                id_valid;
  logic                id_ready;
  logic [XLEN-1:0]     id_pc;
  logic [4:0]          id_rs1;
  logic [4:0]          id_rs2;
  logic [XLEN-1:0]     id_rs1_data;
  logic [XLEN-1:0]     id_rs2_data;
  logic [XLEN-1:0]     id_imm;
  logic                id_alusrc;
  logic [ALUCTL_W-1:0] id_alucontrol;
  logic [4:0]          id_rd;
  logic                id_regwrite;
  logic                id_branch;
  logic                ex_ready;
  logic                flush;
  logic [4:0]          mem_rd;
  logic                mem_regwrite;
  logic [XLEN-1:0]     mem_result;
  logic [4:0]          wb_rd;
  logic                wb_regwrite;
  logic [XLEN-1:0]     wb_result;
  logic                ex_valid;
  logic [XLEN-1:0]     ex_pc;
  logic [XLEN-1:0]     ex_alu_a;
  logic [XLEN-1:0]     ex_alu_b;
  logic [ALUCTL_W-1:0] ex_alucontrol;
  logic [XLEN-1:0]     ex_store_data;
  logic [4:0]          ex_rd;
  logic                ex_regwrite;
  logic                ex_branch;

  int n_checks = 0;
  int n_fails  = 0;

  cpu6_idex_stage #(.XLEN(XLEN), .ALUCTL_W(ALUCTL_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_alucontrol(id_alucontrol),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_branch(id_branch),
    .ex_ready(ex_ready), .flush(flush),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_a(ex_alu_a),
    .ex_alu_b(ex_alu_b), .ex_alucontrol(ex_alucontrol),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_branch(ex_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                          input logic alusrc, input logic [2:0] ctl, input logic [4:0] rd,
                          input logic rw, input logic br);
    id_valid      = 1'b1;
    id_pc         = pc;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rs1_data   = d1;
    id_rs2_data   = d2;
    id_imm        = imm;
    id_alusrc     = alusrc;
    id_alucontrol = ctl;
    id_rd         = rd;
    id_regwrite   = rw;
    id_branch     = br;
  endtask

  task automatic clear_fwd();
    mem_rd = '0; mem_regwrite = 1'b0; mem_result = '0;
    wb_rd  = '0; wb_regwrite  = 1'b0; wb_result  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    drive_id(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd0, 1'b0, 1'b0);
    id_valid = 1'b0;
    clear_fwd();

    // reset state
    #12;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);
    chk("rst_alu_a",    ex_alu_a,      32'h0);
    chk("rst_regwrite", 32'(ex_regwrite), 32'd0);
    reset = 1'b0;

    // first accept: ADD 5 + 7
    drive_id(32'h100, 5'd1, 5'd2, 32'd5, 32'd7, 32'h0, 1'b0, 3'd0, 5'd4, 1'b1, 1'b0);
    tick();
    chk("acc_ex_valid", 32'(ex_valid), 32'd1);
    chk("acc_alu_a",    ex_alu_a, 32'd5);
    chk("acc_alu_b",    ex_alu_b, 32'd7);
    chk("acc_id_ready", 32'(id_ready), 32'd1);
    chk("acc_pc",       ex_pc, 32'h100);
    chk("acc_rd",       32'(ex_rd), 32'd4);
    chk("acc_regwrite", 32'(ex_regwrite), 32'd1);

    // immediate-source branch; check forwarding priority on registered rs1=3
    drive_id(32'h104, 5'd3, 5'd5, 32'h33, 32'h55, 32'h1234, 1'b1, 3'd2, 5'd0, 1'b0, 1'b1);
    tick();
    id_valid = 1'b0;
    chk("imm_alu_b",    ex_alu_b, 32'h1234);
    chk("imm_store",    ex_store_data, 32'h55);
    chk("imm_branch",   32'(ex_branch), 32'd1);
    chk("imm_regwrite", 32'(ex_regwrite), 32'd0);
    chk("imm_aluctl",   32'(ex_alucontrol), 32'd2);
    mem_rd = 5'd3; mem_regwrite = 1'b1; mem_result = 32'h11;
    wb_rd  = 5'd3; wb_regwrite  = 1'b1; wb_result  = 32'h22;
    #1 chk("fwd_mem_prio", ex_alu_a, 32'h11);
    mem_regwrite = 1'b0;
    #1 chk("fwd_wb",       ex_alu_a, 32'h22);
    wb_rd = 5'd5; wb_result = 32'h66;
    #1 chk("fwd_none_a",   ex_alu_a, 32'h33);
    chk("fwd_wb_store",    ex_store_data, 32'h66);
    chk("fwd_imm_hold_b",  ex_alu_b, 32'h1234);
    clear_fwd();

    // bubble: branch control must drop with valid
    tick();
    chk("bub_ex_valid", 32'(ex_valid), 32'd0);
    chk("bub_branch",   32'(ex_branch), 32'd0);
    chk("bub_id_ready", 32'(id_ready), 32'd1);

    // x0 guard on rs2
    drive_id(32'h108, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 3'd0, 5'd1, 1'b1, 1'b0);
    tick();
    id_valid = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b1; mem_result = 32'hFF;
    wb_rd  = 5'd0; wb_regwrite  = 1'b1; wb_result  = 32'hEE;
    #1;
    chk("x0_store", ex_store_data, 32'h0);
    chk("x0_alu_b", ex_alu_b, 32'h0);
    chk("x0_alu_a", ex_alu_a, 32'h0);
    clear_fwd();

    // stall with refresh: rs1=6 gets 0x44 from WB only in stall cycle 1
    drive_id(32'h200, 5'd6, 5'd7, 32'h60, 32'h70, 32'h0, 1'b0, 3'd1, 5'd9, 1'b1, 1'b0);
    tick();
    ex_ready = 1'b0;
    drive_id(32'h300, 5'd8, 5'd8, 32'h80, 32'h81, 32'h0, 1'b0, 3'd3, 5'd10, 1'b1, 1'b1);
    wb_rd = 5'd6; wb_regwrite = 1'b1; wb_result = 32'h44;
    #1;
    chk("stl1_id_ready", 32'(id_ready), 32'd0);
    chk("stl1_alu_a",    ex_alu_a, 32'h44);
    tick();
    clear_fwd();
    #1;
    chk("stl2_id_ready", 32'(id_ready), 32'd0);
    chk("stl2_alu_a",    ex_alu_a, 32'h44);
    tick();
    chk("stl3_id_ready", 32'(id_ready), 32'd0);
    chk("stl3_alu_a",    ex_alu_a, 32'h44);
    chk("stl3_pc",       ex_pc, 32'h200);
    chk("stl3_alu_b",    ex_alu_b, 32'h70);
    chk("stl3_rd",       32'(ex_rd), 32'd9);
    chk("stl3_valid",    32'(ex_valid), 32'd1);

    // flush beats accept and stall
    flush = 1'b1;
    tick();
    flush = 1'b0;
    id_valid = 1'b0;
    chk("fl_ex_valid", 32'(ex_valid), 32'd0);
    chk("fl_regwrite", 32'(ex_regwrite), 32'd0);
    chk("fl_branch",   32'(ex_branch), 32'd0);
    chk("fl_id_ready", 32'(id_ready), 32'd1);

    // async reset while stalled
    ex_ready = 1'b1;
    drive_id(32'h400, 5'd9, 5'd1, 32'h99, 32'h1, 32'h0, 1'b0, 3'd0, 5'd2, 1'b1, 1'b1);
    tick();
    id_valid = 1'b0;
    ex_ready = 1'b0;
    tick();
    chk("ar_pre_valid", 32'(ex_valid), 32'd1);
    chk("ar_pre_alu_a", ex_alu_a, 32'h99);
    #2 reset = 1'b1;
    #1;
    chk("ar_ex_valid", 32'(ex_valid), 32'd0);
    chk("ar_alu_a",    ex_alu_a, 32'h0);
    chk("ar_pc",       ex_pc, 32'h0);
    chk("ar_branch",   32'(ex_branch), 32'd0);
    chk("ar_id_ready", 32'(id_ready), 32'd1);
    #2 reset = 1'b0;

    // first edge after reset release accepts
    drive_id(32'h500, 5'd1, 5'd2, 32'hAB, 32'hCD, 32'h0, 1'b0, 3'd0, 5'd3, 1'b1, 1'b0);
    tick();
    id_valid = 1'b0;
    chk("post_rst_valid", 32'(ex_valid), 32'd1);
    chk("post_rst_alu_a", ex_alu_a, 32'hAB);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
